// File: rtl/burst_ram_responder_if.sv
// Burst read/write request bus between a memory initiator (master) and the
// memory-side responder (slave). Clock and reset are carried separately.
interface burst_ram_responder_if #(
   parameter int MEM_DATA_BITS = 64,
   parameter int ADDR_BITS     = 32
);
   logic                     rd_burst_req;
   logic                     wr_burst_req;
   logic [9:0]               rd_burst_len;
   logic [9:0]               wr_burst_len;
   logic [ADDR_BITS-1:0]     rd_burst_addr;
   logic [ADDR_BITS-1:0]     wr_burst_addr;
   logic                     wr_burst_data_req;
   logic [MEM_DATA_BITS-1:0] wr_burst_data;
   logic                     rd_burst_data_valid;
   logic [MEM_DATA_BITS-1:0] rd_burst_data;
   logic                     wr_burst_finish;
   logic                     rd_burst_finish;

   modport master (
      output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
             rd_burst_addr, wr_burst_addr, wr_burst_data,
      input  wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
             wr_burst_finish, rd_burst_finish
   );

   modport slave (
      input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
             rd_burst_addr, wr_burst_addr, wr_burst_data,
      output wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
             wr_burst_finish, rd_burst_finish
   );
endinterface

// File: rtl/burst_ram_responder.sv
// Memory-side burst responder backed by an internal synchronous RAM model.
// Serves one read or write burst at a time; write wins when both request.
// Optional build macro BURST_RAM_STALL_EN inserts pseudo-random stall cycles
// (16-bit LFSR) into the beat request / RAM read issue stream.
module burst_ram_responder #(
   parameter int MEM_DATA_BITS = 64,
   parameter int ADDR_BITS     = 32,
   parameter int RAM_AW        = 10
) (
   input  logic                 mem_clk,
   input  logic                 rst_n,
   burst_ram_responder_if.slave bus,
   output logic                 busy
);

   typedef enum logic [2:0] {
      IDLE, WR_BURST, WR_FIN, RD_BURST, RD_WAIT, RD_FIN
   } state_t;

   state_t                   state;
   logic [9:0]               len_q;
   logic [9:0]               cnt;
   logic [RAM_AW-1:0]        wr_ptr;
   logic [RAM_AW-1:0]        rd_ptr;
   logic                     wr_vld_p1;
   logic                     stall;
   logic [MEM_DATA_BITS-1:0] mem [2**RAM_AW];

   // Upper address bits are deliberately ignored: the RAM index wraps.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.wr_burst_addr[ADDR_BITS-1:RAM_AW],
                               bus.rd_burst_addr[ADDR_BITS-1:RAM_AW]};

`ifdef BURST_RAM_STALL_EN
   logic [15:0] lfsr;

   // Free-running LFSR; bit 0 high withholds this cycle's beat request or read
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) lfsr <= 16'hACE1;
      else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   // RAM write port: captures the beat presented one cycle after each data_req
   always_ff @(posedge mem_clk) begin
      if (wr_vld_p1) mem[wr_ptr] <= bus.wr_burst_data;
   end

   // Burst control FSM with registered handshake outputs and read data
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         state                   <= IDLE;
         len_q                   <= '0;
         cnt                     <= '0;
         wr_ptr                  <= '0;
         rd_ptr                  <= '0;
         wr_vld_p1               <= 1'b0;
         busy                    <= 1'b0;
         bus.wr_burst_data_req   <= 1'b0;
         bus.rd_burst_data_valid <= 1'b0;
         bus.rd_burst_data       <= '0;
         bus.wr_burst_finish     <= 1'b0;
         bus.rd_burst_finish     <= 1'b0;
      end else begin
         bus.wr_burst_data_req   <= 1'b0;
         bus.rd_burst_data_valid <= 1'b0;
         bus.wr_burst_finish     <= 1'b0;
         bus.rd_burst_finish     <= 1'b0;
         wr_vld_p1               <= bus.wr_burst_data_req;
         if (wr_vld_p1) wr_ptr <= wr_ptr + RAM_AW'(1);

         case (state)
            IDLE: begin
               if (bus.wr_burst_req) begin
                  len_q  <= bus.wr_burst_len;
                  wr_ptr <= bus.wr_burst_addr[RAM_AW-1:0];
                  busy   <= 1'b1;
                  if (bus.wr_burst_len == 10'd0) begin
                     cnt                 <= '0;
                     state               <= WR_FIN;
                     bus.wr_burst_finish <= 1'b1;
                  end else begin
                     // First beat request goes out with the acceptance edge
                     cnt                   <= {9'd0, ~stall};
                     state                 <= WR_BURST;
                     bus.wr_burst_data_req <= ~stall;
                  end
               end else if (bus.rd_burst_req) begin
                  len_q  <= bus.rd_burst_len;
                  rd_ptr <= bus.rd_burst_addr[RAM_AW-1:0];
                  cnt    <= '0;
                  busy   <= 1'b1;
                  if (bus.rd_burst_len == 10'd0) begin
                     state               <= RD_FIN;
                     bus.rd_burst_finish <= 1'b1;
                  end else begin
                     state <= RD_BURST;
                  end
               end
            end
            WR_BURST: begin
               if (cnt == len_q) begin
                  // Last request already out; its beat lands during WR_FIN
                  state               <= WR_FIN;
                  bus.wr_burst_finish <= 1'b1;
               end else if (!stall) begin
                  bus.wr_burst_data_req <= 1'b1;
                  cnt                   <= cnt + 10'd1;
               end
            end
            WR_FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            RD_BURST: begin
               if (!stall) begin
                  bus.rd_burst_data       <= mem[rd_ptr];
                  bus.rd_burst_data_valid <= 1'b1;
                  rd_ptr                  <= rd_ptr + RAM_AW'(1);
                  cnt                     <= cnt + 10'd1;
                  if (cnt + 10'd1 == len_q) state <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               state               <= RD_FIN;
               bus.rd_burst_finish <= 1'b1;
            end
            RD_FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/burst_ram_responder.md
# burst_ram_responder

Memory-side responder for the burst read/write request interface driven by the team's memory test and traffic initiators. Accepts one burst request at a time, streams write data into an internal synchronous RAM model, and returns read data with valid/finish handshakes. Sits in place of the DDR controller burst port, for simulation and on-chip loopback of initiators without external memory.

## Interface
Parameters:
- MEM_DATA_BITS, 64, data beat width
- ADDR_BITS, 32, burst address width (word address, one word = one beat)
- RAM_AW, 10, log2 of RAM depth in words (1024 words)

Ports:
- mem_clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_burst_req  in  1  read request level, held until rd_burst_finish
- wr_burst_req  in  1  write request level, held until wr_burst_finish
- rd_burst_len  in  10  read beat count, sampled at acceptance
- wr_burst_len  in  10  write beat count, sampled at acceptance
- rd_burst_addr  in  ADDR_BITS  read start word address, sampled at acceptance
- wr_burst_addr  in  ADDR_BITS  write start word address, sampled at acceptance
- wr_burst_data_req  out  1  beat request; initiator presents data the following cycle
- wr_burst_data  in  MEM_DATA_BITS  write beat
- rd_burst_data_valid  out  1  rd_burst_data holds a valid beat
- rd_burst_data  out  MEM_DATA_BITS  read beat
- wr_burst_finish  out  1  one-cycle pulse, write burst complete
- rd_burst_finish  out  1  one-cycle pulse, read burst complete
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, WR_BURST, WR_FIN, RD_BURST, RD_WAIT, RD_FIN.
- IDLE: wr_burst_req=1 -> latch wr len/addr, go WR_BURST (len=0 -> WR_FIN). Else rd_burst_req=1 -> latch rd len/addr, go RD_BURST (len=0 -> RD_FIN). Both high: write wins.
- WR_BURST: wr_burst_data_req=1 each issuing cycle; beat counter increments per pulse; after len-th pulse go WR_FIN.
- Capture: wr_burst_data written to RAM at word pointer in the cycle after each wr_burst_data_req pulse; pointer increments per capture.
- WR_FIN: capture of last beat; wr_burst_finish=1; -> IDLE.
- RD_BURST: one RAM read issued per cycle at word pointer; after len-th issue go RD_WAIT.
- RD_WAIT: last beat valid on output; -> RD_FIN. RD_FIN: rd_burst_finish=1; -> IDLE.
- RAM index = (latched addr + beat index) mod 2^RAM_AW; upper address bits ignored; wraps within a burst.
- Request inputs ignored outside IDLE. Initiator must drop/change req by the cycle after finish; IDLE re-samples then, so a held req restarts a new burst.
- Reset: all outputs 0, state IDLE, counters/pointers 0. RAM contents not reset. Reset mid-burst aborts silently; no finish pulse.
- rd_burst_data after reset is 0; between valids it holds last beat.

## Timing
- Request sampled high in IDLE at cycle T.
- Write, len N, no stall: data_req high T+1..T+N; captures T+2..T+N+1; wr_burst_finish at T+N+1; IDLE at T+N+2.
- Read, len N, no stall: RAM issue T+1..T+N; rd_burst_data_valid T+2..T+N+1 (one-cycle RAM latency); rd_burst_finish T+N+2.
- len=0: finish at T+1, no data_req/valid.
- Read-after-write to same address in back-to-back bursts returns new data (write completes before finish).
- Outputs are registered.

## Configuration
- BURST_RAM_STALL_EN defined: 16-bit LFSR (seed 16'hACE1 at reset, advanced every cycle) inserts stall cycles; when LFSR bit 0 is 1 in WR_BURST/RD_BURST, no data_req / no RAM issue that cycle. Captures still follow each data_req by exactly one cycle; valids become non-contiguous; finish still follows last capture/valid as above.
- Undefined: no stalls; timing exactly as in Timing.

## Test plan
- Write len 128 at 'h2000000, data beat k = {8{k[7:0]}} -> 128 contiguous data_req pulses, finish at T+129; then read len 128 same addr -> 128 valids returning {8{k}}, finish at T+130.
- wr_burst_req and rd_burst_req both high in IDLE -> write burst served first, read served after wr finish.
- Write len 4 at addr 1022 (RAM_AW=10) -> words 1022,1023,0,1 written; read len 2 at addr 0 returns beats 2,3.
- len 0 write -> wr_burst_finish at T+1, no data_req; len 0 read -> rd_burst_finish at T+1, no valid.
- rst_n low during beat 50 of a 128-beat write -> all outputs 0 next cycle, no finish; after release new 8-beat write completes normally.
- With BURST_RAM_STALL_EN: 128-beat write/read round trip -> data compares clean, exactly 128 data_req and 128 valid pulses, one finish each.
